// File: rtl/mips_pkg.sv
// Shared constants for the single-cycle MIPS SoC: memory map, opcodes,
// function codes and the ALU operation set.
package mips_pkg;

    localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
    localparam logic [31:0] DATA_BASE  = 32'h1001_0000;
    localparam int          IMEM_WORDS = 2048;
    localparam int          DMEM_WORDS = 2048;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    function automatic logic [10:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        logic [31:0] off;
        off = addr - base;
        return off[12:2];
    endfunction

endpackage

// File: rtl/cpu.sv
// Single-cycle MIPS core: decode, ALU, next-PC and register file; one
// instruction retires on every rising clock edge.
module cpu
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] pc,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        dmem_we
);

    logic [31:0] pc_q, pc_d;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, sh;
    logic [15:0] imm;
    logic [31:0] imm_ext, rs_val, rt_val, alu_b, alu_y, pc_plus4;
    logic [31:0] wdata;
    logic [4:0]  waddr;
    alu_op_e     alu_op;
    logic b_imm, zext, shift_var, reg_we, dst_rd, mem_to_reg;
    logic is_beq, is_bne, is_j, is_jal, is_jr;

    assign op    = inst[31:26];
    assign rs    = inst[25:21];
    assign rt    = inst[20:16];
    assign rd    = inst[15:11];
    assign shamt = inst[10:6];
    assign funct = inst[5:0];
    assign imm   = inst[15:0];

    always_comb begin
        alu_op     = ALU_ADD;
        b_imm      = 1'b0;
        zext       = 1'b0;
        shift_var  = 1'b0;
        reg_we     = 1'b0;
        dst_rd     = 1'b0;
        mem_to_reg = 1'b0;
        dmem_we    = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        is_jal     = 1'b0;
        is_jr      = 1'b0;
        case (op)
            OP_RTYPE: begin
                dst_rd = 1'b1;
                reg_we = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    FN_SRA:  alu_op = ALU_SRA;
                    FN_SLLV: begin alu_op = ALU_SLL; shift_var = 1'b1; end
                    FN_SRLV: begin alu_op = ALU_SRL; shift_var = 1'b1; end
                    FN_SRAV: begin alu_op = ALU_SRA; shift_var = 1'b1; end
                    FN_JR:   begin is_jr = 1'b1; reg_we = 1'b0; end
                    default: reg_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin b_imm = 1'b1; reg_we = 1'b1; end
            OP_SLTI:  begin alu_op = ALU_SLT;  b_imm = 1'b1; reg_we = 1'b1; end
            OP_SLTIU: begin alu_op = ALU_SLTU; b_imm = 1'b1; reg_we = 1'b1; end
            OP_ANDI: begin alu_op = ALU_AND; b_imm = 1'b1; zext = 1'b1; reg_we = 1'b1; end
            OP_ORI:  begin alu_op = ALU_OR;  b_imm = 1'b1; zext = 1'b1; reg_we = 1'b1; end
            OP_XORI: begin alu_op = ALU_XOR; b_imm = 1'b1; zext = 1'b1; reg_we = 1'b1; end
            OP_LUI:  begin alu_op = ALU_LUI; reg_we = 1'b1; end
            OP_LW: begin b_imm = 1'b1; reg_we = 1'b1; mem_to_reg = 1'b1; end
            OP_SW: begin b_imm = 1'b1; dmem_we = 1'b1; end
            OP_BEQ: is_beq = 1'b1;
            OP_BNE: is_bne = 1'b1;
            OP_J:   is_j = 1'b1;
            OP_JAL: begin is_jal = 1'b1; reg_we = 1'b1; end
            default: ;
        endcase
    end

    regfile cpu_ref (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rs_val),
        .rdata2 (rt_val),
        .we     (reg_we),
        .waddr  (waddr),
        .wdata  (wdata)
    );

    assign imm_ext = zext ? {16'd0, imm} : {{16{imm[15]}}, imm};
    assign alu_b   = b_imm ? imm_ext : rt_val;
    assign sh      = shift_var ? rs_val[4:0] : shamt;

    always_comb begin
        alu_y = '0;
        case (alu_op)
            ALU_ADD:  alu_y = rs_val + alu_b;
            ALU_SUB:  alu_y = rs_val - alu_b;
            ALU_AND:  alu_y = rs_val & alu_b;
            ALU_OR:   alu_y = rs_val | alu_b;
            ALU_XOR:  alu_y = rs_val ^ alu_b;
            ALU_NOR:  alu_y = ~(rs_val | alu_b);
            ALU_SLT:  alu_y = {31'd0, $signed(rs_val) < $signed(alu_b)};
            ALU_SLTU: alu_y = {31'd0, rs_val < alu_b};
            ALU_SLL:  alu_y = alu_b << sh;
            ALU_SRL:  alu_y = alu_b >> sh;
            ALU_SRA:  alu_y = $unsigned($signed(alu_b) >>> sh);
            ALU_LUI:  alu_y = {imm, 16'd0};
            default:  alu_y = '0;
        endcase
    end

    assign pc_plus4   = pc_q + 32'd4;
    assign dmem_addr  = alu_y;
    assign dmem_wdata = rt_val;
    assign waddr      = is_jal ? 5'd31 : (dst_rd ? rd : rt);
    assign wdata      = is_jal ? pc_plus4 : (mem_to_reg ? dmem_rdata : alu_y);

    always_comb begin
        pc_d = pc_plus4;
        if ((is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val)))
            pc_d = pc_plus4 + {imm_ext[29:0], 2'b00};
        else if (is_j || is_jal)
            pc_d = {pc_plus4[31:28], inst[25:0], 2'b00};
        else if (is_jr)
            pc_d = rs_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= TEXT_BASE;
        else     pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/dram.sv
// Data RAM: asynchronous word read, synchronous word write.
module dram
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [31:0] data_array [0:DMEM_WORDS-1];
    logic [10:0] idx;

    assign idx   = word_index(addr, DATA_BASE);
    assign rdata = data_array[idx];

    always_ff @(posedge clk) begin
        if (we) data_array[idx] <= wdata;
    end

endmodule

// File: rtl/iram.sv
// Instruction RAM, loaded by back-door; asynchronous word read.
module iram
    import mips_pkg::*;
(
    input  logic [31:0] addr,
    output logic [31:0] inst
);

    logic [31:0] inst_array [0:IMEM_WORDS-1];

    assign inst = inst_array[word_index(addr, TEXT_BASE)];

endmodule

// File: rtl/regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port; $0 is hardwired to zero.
module regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] array_reg [0:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) array_reg[i] <= '0;
        end else if (we && (waddr != 5'd0)) begin
            array_reg[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : array_reg[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : array_reg[raddr2];

endmodule

// File: rtl/sccomp_dataflow_soc.sv
// SoC top: single-cycle MIPS core with word-addressed instruction and
// data RAMs; exposes PC and fetched instruction for tracing.
module sccomp_dataflow_soc
    import mips_pkg::*;
(
    input  logic        clk_in,
    input  logic        reset,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_we;

    iram iram_inst (
        .addr (pc),
        .inst (inst)
    );

    dram dram_inst (
        .clk   (clk_in),
        .we    (dmem_we),
        .addr  (dmem_addr),
        .wdata (dmem_wdata),
        .rdata (dmem_rdata)
    );

    cpu sccpu (
        .clk        (clk_in),
        .rst        (reset),
        .inst       (inst),
        .dmem_rdata (dmem_rdata),
        .pc         (pc),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we)
    );

endmodule

// File: tb/tb_sccomp_dataflow_soc.sv
// Scoreboard bench for sccomp_dataflow_soc: a directed program with
// hand-computed architectural state after every retired instruction.
module tb_sccomp_dataflow_soc;

    localparam logic [31:0] TB = 32'h0040_0000;

    logic        clk_in = 1'b0;
    logic        reset  = 1'b1;
    logic [31:0] inst, pc;

    sccomp_dataflow_soc dut (
        .clk_in (clk_in),
        .reset  (reset),
        .inst   (inst),
        .pc     (pc)
    );

    always #5 clk_in = ~clk_in;

    // kind: 0 pc, 1 register, 2 data word, 3 fetched instruction
    typedef struct {
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    logic [31:0] prog [0:28] = '{
        32'h3C011234, 32'h34215678, 32'h2002FFFF, 32'h3C011001,
        32'hAC220004, 32'h8C230004, 32'h20000005, 32'h10000002,
        32'h20050007, 32'h20050007, 32'h14000002, 32'h0C100010,
        32'h3C068000, 32'h00063903, 32'h0002202B, 32'h08100011,
        32'h03E00008, 32'h0040402A, 32'h00224820, 32'h00225022,
        32'h00C75826, 32'h00206027, 32'h00066902, 32'h00817004,
        32'h304F8001, 32'h2C90FFFF, 32'h28510000, 32'h00C49025,
        32'h0810001C
    };

    // per-edge expectation: pc offset, checked kind/index/value
    logic [31:0] e_pc  [1:27] = '{
        32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h28,
        32'h2C, 32'h40, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h44, 32'h48,
        32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C, 32'h60, 32'h64, 32'h68,
        32'h6C, 32'h70, 32'h70
    };
    int          e_knd [1:27] = '{
        1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 1, 1, 1,
        1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1
    };
    int          e_idx [1:27] = '{
        1, 1, 2, 1, 1, 3, 0, 5, 0, 31, 31, 6, 7, 4,
        4, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 18
    };
    logic [31:0] e_val [1:27] = '{
        32'h12340000, 32'h12345678, 32'hFFFFFFFF, 32'h10010000,
        32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000,
        32'h00000000, 32'h00400030, 32'h00400030, 32'h80000000,
        32'hF8000000, 32'h00000001, 32'h00000001, 32'h00000001,
        32'h1000FFFF, 32'h10010001, 32'h78000000, 32'hEFFEFFFF,
        32'h08000000, 32'h20020000, 32'h00008001, 32'h00000001,
        32'h00000001, 32'h80000001, 32'h80000001
    };

    task automatic push(input int k, input int i, input logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.idx  = i;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic push_pc(input logic [31:0] off);
        logic [31:0] w;
        w = off >> 2;
        push(0, 0, TB + off);
        push(3, 0, (w < 29) ? prog[w] : 32'h0);
    endtask

    // monitor: drains every expectation queued since the last falling edge
    initial begin
        forever begin
            @(negedge clk_in);
            while (q.size() > 0) begin
                exp_t        e;
                logic [31:0] got;
                string       nm;
                e = q.pop_front();
                case (e.kind)
                    0: begin got = pc; nm = "pc"; end
                    1: begin got = dut.sccpu.cpu_ref.array_reg[e.idx]; nm = "reg"; end
                    2: begin got = dut.dram_inst.data_array[e.idx]; nm = "dmem"; end
                    default: begin got = inst; nm = "inst"; end
                endcase
                n_vec++;
                if (got !== e.val) begin
                    n_fail++;
                    $display("FAIL %s[%0d] @%0t: got %h expected %h",
                             nm, e.idx, $time, got, e.val);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 2048; i++) begin
            dut.iram_inst.inst_array[i] = (i < 29) ? prog[i] : 32'h0;
            dut.dram_inst.data_array[i] = 32'h0;
        end
        #12;
        push_pc(32'h0);
        for (int r = 0; r < 32; r++) push(1, r, 32'h0);
        @(posedge clk_in);
        #1;
        push_pc(32'h0);
        @(negedge clk_in);
        reset = 1'b0;

        for (int k = 1; k <= 27; k++) begin
            @(posedge clk_in);
            #1;
            push_pc(e_pc[k]);
            push(e_knd[k], e_idx[k], e_val[k]);
        end

        @(negedge clk_in);
        #2;
        reset = 1'b1;
        #1;
        push_pc(32'h0);
        push(1, 1, 32'h0);
        push(1, 31, 32'h0);
        push(1, 18, 32'h0);
        push(2, 1, 32'hFFFFFFFF);
        @(negedge clk_in);
        #1;
        reset = 1'b0;
        @(posedge clk_in);
        #1;
        push_pc(32'h04);
        push(1, 1, 32'h12340000);
        @(negedge clk_in);
        @(negedge clk_in);
        #1;
        if (q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL queue: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
